// File: rtl/onchip_mem_bist_engine_if.sv
// ----------------------------------------------------------------------------
// onchip_mem_bist_engine_if
// Purpose : bundles the BIST control/status handshake and the s1-style RAM
//           port driven by onchip_mem_bist_engine.
// Signals :
//   start, pattern_sel, seed          control into the engine
//   busy, done, pass, err_count,
//   first_err_addr                    status out of the engine
//   mem_address, mem_byteenable,
//   mem_chipselect, mem_write,
//   mem_writedata, mem_clken          RAM command outputs of the engine
//   mem_readdata                      RAM read data into the engine
// Modports: master = the engine, slave = the RAM / controlling host side.
// ----------------------------------------------------------------------------
interface onchip_mem_bist_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                  start;
  logic [1:0]            pattern_sel;
  logic [DATA_W-1:0]     seed;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_W:0]       err_count;
  logic [ADDR_W-1:0]     first_err_addr;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [DATA_W-1:0]     mem_writedata;
  logic                  mem_clken;
  logic [DATA_W-1:0]     mem_readdata;

  modport master (
    input  start, pattern_sel, seed, mem_readdata,
    output busy, done, pass, err_count, first_err_addr,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken
  );

  modport slave (
    output start, pattern_sel, seed, mem_readdata,
    input  busy, done, pass, err_count, first_err_addr,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_mem_bist_engine.sv
// ----------------------------------------------------------------------------
// onchip_mem_bist_engine
// Purpose : built-in self-test master for a single-port on-chip RAM. On start
//           it writes a selectable pattern to every word, reads every word
//           back, compares against the same pattern and reports pass/fail,
//           the number of mismatching words and the first failing address.
// Ports   :
//   clk      in  system clock
//   reset_n  in  synchronous reset, active low
//   bus      master modport of onchip_mem_bist_engine_if
//            (control: start/pattern_sel/seed; status: busy/done/pass/
//             err_count/first_err_addr; RAM: mem_* command, mem_readdata)
// Patterns: 0 addr, 1 seed^addr, 2 checkerboard (odd words ~seed), 3 seed+addr
// ----------------------------------------------------------------------------
module onchip_mem_bist_engine #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  onchip_mem_bist_engine_if.master bus
);

  localparam int                CNT_W      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_sel;
  logic [DATA_W-1:0]   r_seed;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cs;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_clken;
  logic [CNT_W-1:0]    r_drain_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ADDR_W:0]     r_err_count;
  logic [ADDR_W-1:0]   r_first_err_addr;

  // Expected word for a given address under the captured pattern settings.
  function automatic logic [DATA_W-1:0] f_expected(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] sd,
    input logic [ADDR_W-1:0] addr
  );
    logic [DATA_W-1:0] w_a;
    w_a = DATA_W'(addr);
    case (sel)
      2'd0:    return w_a;
      2'd1:    return sd ^ w_a;
      2'd2:    return addr[0] ? ~sd : sd;
      default: return sd + w_a;
    endcase
  endfunction

  // Read-compare alignment pipeline: each stage carries {valid, addr, E(addr)}
  // so the tail stage lines up with mem_readdata for the read it describes.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
    logic              r_vld;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_exp;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_vld   <= 1'b0;
          r_paddr <= '0;
          r_exp   <= '0;
        end else begin
          r_vld   <= (r_state == S_READ);
          r_paddr <= r_addr;
          r_exp   <= f_expected(r_sel, r_seed, r_addr);
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_vld   <= 1'b0;
          r_paddr <= '0;
          r_exp   <= '0;
        end else begin
          r_vld   <= g_pipe[gi-1].r_vld;
          r_paddr <= g_pipe[gi-1].r_paddr;
          r_exp   <= g_pipe[gi-1].r_exp;
        end
      end
    end
  end

  logic              w_cmp_vld;
  logic [ADDR_W-1:0] w_cmp_addr;
  logic [DATA_W-1:0] w_cmp_exp;
  logic              w_mismatch;
  logic [ADDR_W:0]   w_err_inc;
  logic [ADDR_W:0]   w_err_after;

  assign w_cmp_vld   = g_pipe[RD_LATENCY-1].r_vld;
  assign w_cmp_addr  = g_pipe[RD_LATENCY-1].r_paddr;
  assign w_cmp_exp   = g_pipe[RD_LATENCY-1].r_exp;
  assign w_mismatch  = w_cmp_vld && (bus.mem_readdata != w_cmp_exp);
  assign w_err_inc   = (&r_err_count) ? r_err_count : r_err_count + 1'b1;
  // Count including the compare retiring this cycle; the last compare lands in
  // the final DRAIN cycle, so pass must see it before it reaches r_err_count.
  assign w_err_after = w_mismatch ? w_err_inc : r_err_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_sel            <= '0;
      r_seed           <= '0;
      r_addr           <= '0;
      r_cs             <= 1'b0;
      r_we             <= 1'b0;
      r_wdata          <= '0;
      r_clken          <= 1'b0;
      r_drain_cnt      <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      r_clken <= 1'b1;
      r_done  <= 1'b0;

      if (w_mismatch) begin
        r_err_count <= w_err_inc;
        // Zero count means nothing has failed yet in this test.
        if (r_err_count == '0) r_first_err_addr <= w_cmp_addr;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sel            <= bus.pattern_sel;
            r_seed           <= bus.seed;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_busy           <= 1'b1;
            r_addr           <= '0;
            r_cs             <= 1'b1;
            r_we             <= 1'b1;
            r_wdata          <= f_expected(bus.pattern_sel, bus.seed, '0);
            r_state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_addr == LAST_ADDR) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_state <= S_READ;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_wdata <= f_expected(r_sel, r_seed, r_addr + 1'b1);
          end
        end
        S_READ: begin
          if (r_addr == LAST_ADDR) begin
            r_addr      <= '0;
            r_cs        <= 1'b0;
            r_drain_cnt <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == LAST_DRAIN) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_after == '0);
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err_count;
  assign bus.first_err_addr = r_first_err_addr;
  assign bus.mem_address    = r_addr;
  assign bus.mem_byteenable = '1;
  assign bus.mem_chipselect = r_cs;
  assign bus.mem_write      = r_we;
  assign bus.mem_writedata  = r_wdata;
  assign bus.mem_clken      = r_clken;

endmodule

// File: tb/tb_onchip_mem_bist_engine.sv
// ----------------------------------------------------------------------------
// tb_onchip_mem_bist_engine
// Purpose : self-checking bench for onchip_mem_bist_engine. A behavioural RAM
//           with per-word stuck-at masks sits on the memory port; expected
//           status is computed by walking every address with the pattern rules.
// Ports   : none (top-level bench).
// ----------------------------------------------------------------------------
module tb_onchip_mem_bist_engine;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 1024;
  localparam int RDL      = 1;
  localparam int DONE_CYC = 2 * DEPTH + RDL + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_bist_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_bist_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Behavioural RAM: one-cycle registered read, stuck-at faults on read.
  logic [31:0] ram [DEPTH];
  logic [31:0] sa1 [DEPTH];
  logic [31:0] sa0 [DEPTH];
  logic [31:0] wr_log [DEPTH];
  logic [31:0] rdata_q = '0;

  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      else rdata_q <= (ram[bus.mem_address] | sa1[bus.mem_address]) & ~sa0[bus.mem_address];
    end
  end
  assign bus.mem_readdata = rdata_q;

  int n_vec = 0;
  int n_err = 0;

  int          obs_done_cyc, obs_done_cnt, obs_bad_seq, obs_bad_busy;
  logic        obs_pass;
  logic [10:0] obs_errc;
  logic [9:0]  obs_ferr;

  function automatic logic [31:0] exp_word(input int sel, input logic [31:0] sd, input int a);
    case (sel)
      0:       return 32'(a);
      1:       return sd ^ 32'(a);
      2:       return (a % 2 == 1) ? ~sd : sd;
      default: return sd + 32'(a);
    endcase
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      sa1[a] = '0;
      sa0[a] = '0;
    end
  endtask

  // Expected error count / first failing address for the current fault set.
  task automatic model_result(input int sel, input logic [31:0] sd, output int cnt, output int first);
    logic [31:0] w, rd;
    cnt = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      w  = exp_word(sel, sd, a);
      rd = (w | sa1[a]) & ~sa0[a];
      if (rd !== w) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
    if (cnt > 2047) cnt = 2047;
  endtask

  // Pulse start, follow the whole test cycle by cycle and record observations.
  task automatic run_bist(input int sel, input logic [31:0] sd, input int repulse_at);
    logic exp_cs, exp_we;
    int   exp_addr;
    obs_done_cyc = 0; obs_done_cnt = 0; obs_bad_seq = 0; obs_bad_busy = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_sel = 2'(sel); bus.seed = sd;
    for (int k = 1; k <= DONE_CYC + 4; k++) begin
      @(negedge clk);
      bus.start       = (k == repulse_at);
      bus.pattern_sel = 2'($urandom);
      bus.seed        = $urandom;
      exp_cs   = (k <= 2 * DEPTH);
      exp_we   = (k <= DEPTH);
      exp_addr = (k <= DEPTH) ? k - 1 : k - DEPTH - 1;
      if (k <= DEPTH) wr_log[k-1] = bus.mem_writedata;
      if (bus.mem_chipselect !== exp_cs) obs_bad_seq++;
      else if (exp_cs && (bus.mem_write !== exp_we || bus.mem_address !== 10'(exp_addr))) obs_bad_seq++;
      else if (exp_we && bus.mem_writedata !== exp_word(sel, sd, k - 1)) obs_bad_seq++;
      if (bus.busy !== (k <= DONE_CYC)) obs_bad_busy++;
      if (bus.done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) obs_done_cyc = k;
      end
    end
    bus.start = 1'b0;
    obs_pass = bus.pass;
    obs_errc = bus.err_count;
    obs_ferr = bus.first_err_addr;
    $display("run sel=%0d seed=%h done@%0d dones=%0d pass=%0b err_count=%0d first_err_addr=0x%0h",
             sel, sd, obs_done_cyc, obs_done_cnt, obs_pass, obs_errc, obs_ferr);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin n_err++;
      $display("FAIL reset_status: busy/done/pass got %b want 000", {bus.busy, bus.done, bus.pass}); end
    n_vec++; if (bus.err_count !== 11'd0 || bus.first_err_addr !== 10'd0) begin n_err++;
      $display("FAIL reset_counters: err_count %0d first %0d want 0 0", bus.err_count, bus.first_err_addr); end
    n_vec++; if ({bus.mem_chipselect, bus.mem_write, bus.mem_clken} !== 3'b000) begin n_err++;
      $display("FAIL reset_strobes: cs/we/clken got %b want 000", {bus.mem_chipselect, bus.mem_write, bus.mem_clken}); end
    n_vec++; if (bus.mem_address !== 10'd0 || bus.mem_writedata !== 32'd0) begin n_err++;
      $display("FAIL reset_bus: addr %h data %h want 0 0", bus.mem_address, bus.mem_writedata); end
    n_vec++; if (bus.mem_byteenable !== 4'hF) begin n_err++;
      $display("FAIL reset_byteenable: got %h want f", bus.mem_byteenable); end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.mem_clken !== 1'b1 || bus.busy !== 1'b0) begin n_err++;
      $display("FAIL post_reset: clken %b busy %b want 1 0", bus.mem_clken, bus.busy); end
  endtask

  task automatic test_sel0_basic();
    int ecnt, efirst, k;
    clear_faults();
    model_result(0, 32'h0, ecnt, efirst);
    run_bist(0, 32'h0, 0);
    n_vec++; if (obs_done_cyc !== DONE_CYC || obs_done_cnt !== 1) begin n_err++;
      $display("FAIL sel0_done: cycle %0d count %0d want %0d 1", obs_done_cyc, obs_done_cnt, DONE_CYC); end
    n_vec++; if (obs_bad_seq !== 0 || obs_bad_busy !== 0) begin n_err++;
      $display("FAIL sel0_sequence: bad access cycles %0d bad busy cycles %0d want 0 0", obs_bad_seq, obs_bad_busy); end
    n_vec++; if (obs_pass !== 1'b1 || obs_errc !== 11'(ecnt) || obs_ferr !== 10'(efirst)) begin n_err++;
      $display("FAIL sel0_status: pass %b errc %0d first %0d want 1 %0d %0d", obs_pass, obs_errc, obs_ferr, ecnt, efirst); end
    k = $urandom_range(0, DEPTH - 1);
    n_vec++; if (wr_log[k] !== 32'(k)) begin n_err++;
      $display("FAIL sel0_wdata[%0d]: got %h want %h", k, wr_log[k], 32'(k)); end
  endtask

  task automatic test_checkerboard();
    clear_faults();
    run_bist(2, 32'hA5A5A5A5, 0);
    n_vec++; if (wr_log[0] !== 32'hA5A5A5A5 || wr_log[1] !== 32'h5A5A5A5A || wr_log[1023] !== 32'h5A5A5A5A) begin n_err++;
      $display("FAIL ckb_words: w0 %h w1 %h w1023 %h want a5a5a5a5 5a5a5a5a 5a5a5a5a", wr_log[0], wr_log[1], wr_log[1023]); end
    n_vec++; if (obs_bad_seq !== 0 || obs_done_cyc !== DONE_CYC) begin n_err++;
      $display("FAIL ckb_sequence: bad %0d done@%0d want 0 %0d", obs_bad_seq, obs_done_cyc, DONE_CYC); end
    n_vec++; if (obs_pass !== 1'b1 || obs_errc !== 11'd0) begin n_err++;
      $display("FAIL ckb_status: pass %b errc %0d want 1 0", obs_pass, obs_errc); end
  endtask

  task automatic test_stuck_single();
    int ecnt, efirst;
    clear_faults();
    // Bit 5 of 0x123 is already 1 under the address pattern, so a stuck-at-0
    // on that bit is what makes the fault visible.
    sa0[12'h123] = 32'h0000_0020;
    model_result(0, 32'h0, ecnt, efirst);
    run_bist(0, 32'h0, 0);
    n_vec++; if (obs_errc !== 11'(ecnt) || obs_ferr !== 10'(efirst)) begin n_err++;
      $display("FAIL stuck_counts: errc %0d first 0x%0h want %0d 0x%0h", obs_errc, obs_ferr, ecnt, efirst); end
    n_vec++; if (obs_pass !== (ecnt == 0) || obs_done_cnt !== 1) begin n_err++;
      $display("FAIL stuck_pass: pass %b dones %0d want %b 1", obs_pass, obs_done_cnt, ecnt == 0); end
  endtask

  task automatic test_two_faults_wrap();
    int ecnt, efirst;
    clear_faults();
    sa1[3]    = 32'h0000_0001;
    sa1[1000] = 32'h8000_0000;
    model_result(3, 32'hFFFFFFFF, ecnt, efirst);
    run_bist(3, 32'hFFFFFFFF, 0);
    n_vec++; if (obs_bad_seq !== 0) begin n_err++;
      $display("FAIL wrap_wdata: bad access cycles %0d want 0", obs_bad_seq); end
    n_vec++; if (obs_errc !== 11'(ecnt) || obs_ferr !== 10'(efirst) || obs_pass !== (ecnt == 0)) begin n_err++;
      $display("FAIL wrap_status: errc %0d first %0d pass %b want %0d %0d %b", obs_errc, obs_ferr, obs_pass, ecnt, efirst, ecnt == 0); end
  endtask

  task automatic test_start_ignored();
    int          sel;
    logic [31:0] sd;
    sel = $urandom_range(0, 3);
    sd  = $urandom;
    clear_faults();
    run_bist(sel, sd, 600);
    n_vec++; if (obs_done_cnt !== 1 || obs_done_cyc !== DONE_CYC) begin n_err++;
      $display("FAIL repulse_done: count %0d cycle %0d want 1 %0d", obs_done_cnt, obs_done_cyc, DONE_CYC); end
    n_vec++; if (obs_bad_seq !== 0 || obs_bad_busy !== 0 || obs_pass !== 1'b1) begin n_err++;
      $display("FAIL repulse_sequence: bad %0d busy %0d pass %b want 0 0 1", obs_bad_seq, obs_bad_busy, obs_pass); end
  endtask

  task automatic test_reset_mid_test();
    int          found, sel;
    logic [31:0] sd;
    clear_faults();
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_sel = 2'($urandom); bus.seed = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.mem_write === 1'b1 && bus.mem_address === 10'd500) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    n_vec++; if (found != 1) begin n_err++;
      $display("FAIL midreset_reach: write at addr 500 seen %0d want 1", found); end
    reset_n = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0 || bus.mem_chipselect !== 1'b0 || bus.err_count !== 11'd0) begin n_err++;
      $display("FAIL midreset_abort: busy %b cs %b errc %0d want 0 0 0", bus.busy, bus.mem_chipselect, bus.err_count); end
    reset_n = 1'b1;
    sel = $urandom_range(0, 3);
    sd  = $urandom;
    run_bist(sel, sd, 0);
    n_vec++; if (obs_pass !== 1'b1 || obs_errc !== 11'd0 || obs_done_cyc !== DONE_CYC) begin n_err++;
      $display("FAIL midreset_rerun: pass %b errc %0d done@%0d want 1 0 %0d", obs_pass, obs_errc, obs_done_cyc, DONE_CYC); end
  endtask

  task automatic test_random();
    int          sel, nf, a, ecnt, efirst;
    logic [31:0] sd;
    for (int it = 0; it < 3; it++) begin
      clear_faults();
      sel = $urandom_range(0, 3);
      sd  = $urandom;
      nf  = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | (32'h1 << $urandom_range(0, 31));
        else sa0[a] = sa0[a] | (32'h1 << $urandom_range(0, 31));
      end
      model_result(sel, sd, ecnt, efirst);
      run_bist(sel, sd, 0);
      n_vec++; if (obs_bad_seq !== 0 || obs_done_cyc !== DONE_CYC || obs_done_cnt !== 1) begin n_err++;
        $display("FAIL random%0d_sequence: bad %0d done@%0d dones %0d", it, obs_bad_seq, obs_done_cyc, obs_done_cnt); end
      n_vec++; if (obs_errc !== 11'(ecnt) || obs_ferr !== 10'(efirst) || obs_pass !== (ecnt == 0)) begin n_err++;
        $display("FAIL random%0d_status: errc %0d first %0d pass %b want %0d %0d %b",
                 it, obs_errc, obs_ferr, obs_pass, ecnt, efirst, ecnt == 0); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.seed = 32'd0;
    clear_faults();
    test_reset();
    test_sel0_basic();
    test_checkerboard();
    test_stuck_single();
    test_two_faults_wrap();
    test_start_ignored();
    test_reset_mid_test();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
